// File: rtl/micro_pkg.sv
// Shared widths, types and reset constants for the micro fetch path.
package micro_pkg;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned MEM_DEPTH  = 512;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] byte_t;

  localparam addr_t RESET_PC = 9'h000;

  typedef struct packed {
    addr_t addr;
    byte_t data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry first-word-fall-through buffer of fetched bytes and their addresses.
module fetch_fifo
  import micro_pkg::*;
(
  input  logic             clka,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     entry_q [FIFO_DEPTH];
  fetch_entry_t     entry_d [FIFO_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign head_o  = entry_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // Flush discards everything, including a same-cycle push.
  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        entry_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clka) begin
    entry_q <= entry_d;
  end

endmodule

// File: rtl/micro_fetch_unit.sv
// RAM port arbiter (jump > store > fetch) feeding a byte stream to the decoder.
module micro_fetch_unit
  import micro_pkg::*;
(
  input  logic              clka,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              wea,
  input  logic [DATA_W-1:0] douta,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ack,
  input  logic              halt,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_addr,
  input  logic              ins_ready
);

  addr_t            pc_q, pc_d;
  addr_t            tag_q, tag_d;
  logic             inflight_q;
  logic             issue;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign pop        = ins_valid && ins_ready;
  assign push       = inflight_q && !jmp_valid && rst_n;
  assign push_entry = '{addr: tag_q, data: douta};
  assign ins_data   = head.data;
  assign ins_addr   = head.addr;

  // Bytes that will occupy the FIFO after this cycle, excluding a new issue.
  assign occ = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

  always_comb begin
    addra = pc_q;
    dina  = '0;
    wea   = 1'b0;
    st_ack = 1'b0;
    issue = 1'b0;
    tag_d = pc_q;
    pc_d  = pc_q;
    if (!rst_n) begin
      addra = RESET_PC;
    end else if (jmp_valid) begin
      addra = jmp_addr;
      issue = 1'b1;
      tag_d = jmp_addr;
      pc_d  = jmp_addr + addr_t'(1);
    end else if (st_req) begin
      addra  = st_addr;
      dina   = st_data;
      wea    = 1'b1;
      st_ack = 1'b1;
    end else if (!halt && (occ < (CNT_W+1)'(FIFO_DEPTH))) begin
      issue = 1'b1;
      pc_d  = pc_q + addr_t'(1);
    end
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= issue;
    end
  end

  fetch_fifo u_fifo (
    .clka         (clka),
    .rst_n        (rst_n),
    .flush_i      (jmp_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .valid_o      (ins_valid),
    .count_o      (count)
  );

endmodule

// File: tb/tb_micro_fetch_unit.sv
// Directed bench for micro_fetch_unit with a 512x8 registered-read RAM model.
module tb_micro_fetch_unit;

  logic       clka = 1'b0;
  logic       rst_n;
  logic [8:0] addra;
  logic [7:0] dina;
  logic       wea;
  logic [7:0] douta;
  logic       jmp_valid;
  logic [8:0] jmp_addr;
  logic       st_req;
  logic [8:0] st_addr;
  logic [7:0] st_data;
  logic       st_ack;
  logic       halt;
  logic       ins_valid;
  logic [7:0] ins_data;
  logic [8:0] ins_addr;
  logic       ins_ready;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [512];
  logic        loaded = 1'b0;
  logic [16:0] q [$];

  always #5 clka = ~clka;

  micro_fetch_unit dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .addra     (addra),
    .dina      (dina),
    .wea       (wea),
    .douta     (douta),
    .jmp_valid (jmp_valid),
    .jmp_addr  (jmp_addr),
    .st_req    (st_req),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ack    (st_ack),
    .halt      (halt),
    .ins_valid (ins_valid),
    .ins_data  (ins_data),
    .ins_addr  (ins_addr),
    .ins_ready (ins_ready)
  );

  function automatic logic [7:0] init_byte(int i);
    case (i)
      0:       return 8'h11;
      1:       return 8'h22;
      2:       return 8'h33;
      3:       return 8'h44;
      'h1FE:   return 8'h5A;
      'h1FF:   return 8'h5B;
      default: return 8'(i);
    endcase
  endfunction

  // Write-first single-port RAM, preloaded on the first edge (inside reset).
  always @(posedge clka) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_byte(i);
      loaded <= 1'b1;
      douta  <= 8'h00;
    end else if (wea) begin
      mem[addra] <= dina;
      douta      <= dina;
    end else begin
      douta <= mem[addra];
    end
  end

  // Record every accepted byte as {addr, data}.
  always @(negedge clka) begin
    if (rst_n && ins_valid && ins_ready) q.push_back({ins_addr, ins_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic do_jump(input logic [8:0] a);
    jmp_valid = 1'b1;
    jmp_addr  = a;
    cyc(1);
    jmp_valid = 1'b0;
    q.delete();
  endtask

  function automatic logic [16:0] qat(int i);
    if (i < q.size()) return q[i];
    return 17'h1FFFF;
  endfunction

  logic [16:0] exp_stream [8] = '{
    {9'h000, 8'h11}, {9'h001, 8'h22}, {9'h002, 8'h33}, {9'h003, 8'h44},
    {9'h004, 8'h04}, {9'h005, 8'h05}, {9'h006, 8'h06}, {9'h007, 8'h07}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int a5;
    rst_n = 1'b0; jmp_valid = 1'b0; jmp_addr = '0; st_req = 1'b0;
    st_addr = '0; st_data = '0; halt = 1'b0; ins_ready = 1'b1;

    @(negedge clka);
    check("rst_wea", wea, 0);
    check("rst_addra", addra, 0);
    @(negedge clka);
    check("rst_ins_valid", ins_valid, 0);

    // Reset release: first issue in cycle R, first valid in R+2.
    @(posedge clka); #1;
    rst_n = 1'b1;
    q.delete();
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clka);
      if (ins_valid) begin
        lat = k;
        break;
      end
    end
    check("first_latency", lat, 2);

    // Back-pressure for 5 cycles starting at R+6.
    cyc(4);
    ins_ready = 1'b0;
    cyc(1);
    @(negedge clka);
    check("stall_addra_r7", addra, 9'h006);
    cyc(3);
    @(negedge clka);
    check("stall_addra_r10", addra, 9'h006);
    check("stall_valid", ins_valid, 1);
    check("stall_ins_addr", ins_addr, 9'h004);
    check("stall_ins_data", ins_data, 8'h04);
    cyc(1);
    ins_ready = 1'b1;
    cyc(6);
    for (int k = 0; k < 8; k++) check($sformatf("stream_%0d", k), qat(k), exp_stream[k]);

    // Jump with address wrap.
    do_jump(9'h1FE);
    @(negedge clka);
    check("jump_flush_valid", ins_valid, 0);
    cyc(5);
    check("wrap_0", qat(0), {9'h1FE, 8'h5A});
    check("wrap_1", qat(1), {9'h1FF, 8'h5B});
    check("wrap_2", qat(2), {9'h000, 8'h11});

    // Store away from the current fetch stream.
    do_jump(9'h020);
    cyc(4);
    st_req = 1'b1; st_addr = 9'h010; st_data = 8'hA5;
    @(negedge clka);
    check("st_wea", wea, 1);
    check("st_ack", st_ack, 1);
    check("st_addra", addra, 9'h010);
    check("st_dina", dina, 8'hA5);
    cyc(1);
    st_req = 1'b0;
    @(negedge clka);
    check("st_wea_after", wea, 0);
    check("st_ack_after", st_ack, 0);
    cyc(4);
    a5 = 0;
    foreach (q[k]) if (q[k][7:0] == 8'hA5) a5++;
    check("no_a5_stream", a5, 0);
    check("stream_after_st", qat(0), {9'h020, 8'h20});
    do_jump(9'h010);
    cyc(5);
    check("refetch_store_0", qat(0), {9'h010, 8'hA5});
    check("refetch_store_1", qat(1), {9'h011, 8'h11});

    // Jump and store in the same cycle: jump wins, store next cycle.
    jmp_valid = 1'b1; jmp_addr = 9'h030;
    st_req = 1'b1; st_addr = 9'h040; st_data = 8'hC3;
    @(negedge clka);
    check("js_st_ack", st_ack, 0);
    check("js_wea", wea, 0);
    check("js_addra", addra, 9'h030);
    cyc(1);
    jmp_valid = 1'b0;
    q.delete();
    @(negedge clka);
    check("js2_st_ack", st_ack, 1);
    check("js2_wea", wea, 1);
    check("js2_addra", addra, 9'h040);
    check("js2_dina", dina, 8'hC3);
    cyc(1);
    st_req = 1'b0;
    cyc(5);
    check("js_stream_0", qat(0), {9'h030, 8'h30});
    check("js_stream_1", qat(1), {9'h031, 8'h31});
    do_jump(9'h040);
    cyc(5);
    check("js_store_readback", qat(0), {9'h040, 8'hC3});

    // Halt drains the pipeline and stops issue.
    halt = 1'b1;
    cyc(4);
    @(negedge clka);
    check("halt_drained", ins_valid, 0);
    halt = 1'b0;
    cyc(4);

    // Reset mid-stream with a pending store.
    rst_n = 1'b0;
    st_req = 1'b1; st_addr = 9'h050; st_data = 8'h77;
    @(negedge clka);
    check("mrst_wea", wea, 0);
    check("mrst_st_ack", st_ack, 0);
    check("mrst_addra", addra, 9'h000);
    cyc(1);
    @(negedge clka);
    check("mrst_ins_valid", ins_valid, 0);
    cyc(1);
    rst_n = 1'b1;
    st_req = 1'b0;
    q.delete();
    cyc(6);
    check("mrst_stream_0", qat(0), {9'h000, 8'h11});
    check("mrst_stream_1", qat(1), {9'h001, 8'h22});
    do_jump(9'h050);
    cyc(5);
    check("mrst_store_dropped", qat(0), {9'h050, 8'h50});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/micro_fetch_unit.md
Name: micro_fetch_unit

Overview:
Instruction-fetch and memory-port arbiter that sits directly upstream of the 512x8 single-port micro RAM. It drives the RAM's addra/dina/wea and consumes douta, accounting for the RAM's 1-cycle registered read latency. It streams sequential instruction bytes to the decoder over a valid/ready handshake, and it also services jump redirects and data-store requests from the execute stage.

Parameters:
ADDR_W, 9, RAM address width (512 locations)
DATA_W, 8, RAM/instruction byte width
RESET_PC, 9'h000, PC value loaded on reset

Ports:
clka  in  1  single clock; all state updates on posedge
rst_n  in  1  synchronous reset, active-low (sampled on posedge clka)
addra  out  ADDR_W  RAM address, combinational from state and requests
dina  out  DATA_W  RAM write data (st_data when storing, else 0)
wea  out  1  RAM write enable
douta  in  DATA_W  RAM read data, valid the cycle after its address was presented
jmp_valid  in  1  redirect fetch to jmp_addr
jmp_addr  in  ADDR_W  jump target
st_req  in  1  store request
st_addr  in  ADDR_W  store address
st_data  in  DATA_W  store data
st_ack  out  1  store performed this cycle (combinational)
halt  in  1  suppress new fetch issue
ins_valid  out  1  instruction byte available
ins_data  out  DATA_W  instruction byte
ins_addr  out  ADDR_W  address ins_data came from
ins_ready  in  1  decoder accepts byte (pop when ins_valid && ins_ready)

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC, FIFO count=0, inflight=0. While rst_n=0: wea=0, st_ack=0, addra=RESET_PC, ins_valid=0 from the next cycle. An in-flight read is discarded. A store presented during reset is not performed.
- Port priority per cycle: jump > store > fetch. Exactly one RAM access per cycle at most.
- Jump cycle (jmp_valid=1):
  - FIFO flushed; any in-flight return arriving this cycle is discarded.
  - addra=jmp_addr, wea=0, pc<=jmp_addr+1, inflight<=1 with tag jmp_addr. This issue ignores halt.
  - st_ack=0; the store stays pending.
- Store cycle (st_req=1, no jump): addra=st_addr, dina=st_data, wea=1, st_ack=1. No fetch is issued and pc is held. The RAM's write-through douta is never captured, because inflight<=0.
- Fetch issue (no jump/store, halt=0, count - pop + inflight < 2): addra=pc, wea=0, pc<=pc+1, inflight<=1 with tag=pc. Otherwise inflight<=0.
- Capture: if inflight=1 and no jump, douta and the tag are pushed into the FIFO at the next posedge.
- Latency: byte at address A is issued in cycle N and ins_valid is asserted in cycle N+2. Sustained throughput is 1 byte/cycle while ins_ready=1.
- FIFO: 2 entries (data+addr), first-word fall-through. ins_valid = count!=0. Push and pop in the same cycle are legal. The issue rule guarantees no overflow.
- PC arithmetic: ADDR_W-bit, wraps 0x1FF -> 0x000 silently. jmp_addr and st_addr are used unmodified.
- No coherence: a store to an address already in the FIFO or in flight does not update that byte; the stale value is delivered. A later re-fetch sees the new value.
- halt=1 stops new sequential issue only; the in-flight byte still lands and the FIFO still drains.
- ins_data/ins_addr are held stable while ins_valid=1 and ins_ready=0.

Decomposition:
- Shared package micro_pkg: ADDR_W, DATA_W, MEM_DEPTH=512, RESET_PC, byte/address typedefs.
- One sub-module, fetch_fifo: 2-entry FWFT buffer with flush, push, pop and count.
- Arbitration, PC and in-flight tracking live in micro_fetch_unit.

Test Plan:
- Reset release with RAM[0..3]=11,22,33,44 and ins_ready=1 -> ins_valid first asserted 2 cycles after the first issue; ins_data/ins_addr stream 11/000, 22/001, 33/002, 44/003 on consecutive cycles.
- ins_ready=0 for 5 cycles mid-stream -> FIFO fills to 2, addra stops advancing; on release, bytes resume in order with no loss or duplication.
- Jump to 0x1FE with RAM[1FE]=5A, RAM[1FF]=5B, RAM[000]=11 -> delivers 5A/1FE, 5B/1FF, 11/000 (wrap); no pre-jump byte appears after the jump cycle.
- st_req with st_addr=0x010, st_data=A5 -> st_ack=1 and wea=1 for exactly one cycle, A5 never appears on ins_data; a later jump to 0x010 delivers A5/010.
- jmp_valid and st_req in the same cycle -> jump taken, st_ack=0; the store is performed (st_ack=1, wea=1) in the following cycle.
- rst_n=0 mid-stream with st_req=1 -> wea stays 0 and ins_valid=0 on the next cycle; after release, fetch restarts at RESET_PC and the store address keeps its old value.
